// File: rtl/fetch_unit.sv
// Instruction fetch unit: boots from the reset vector at word 0, then streams
// one- and two-word instructions to decode, with stall hold and redirect.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_rdata,
    output logic [15:0] imem_addr,
    output logic [15:0] ir_out,
    output logic [15:0] imm_out,
    output logic [15:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        IMM   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] hold_ir_reg, hold_ir_next;
    logic [15:0] hold_pc_reg, hold_pc_next;
    logic [15:0] ir_reg, ir_next;
    logic [15:0] imm_reg, imm_next;
    logic [15:0] pc_out_reg, pc_out_next;
    logic        valid_reg, valid_next;

    logic        two_word;
    logic        advance;

    assign two_word = imem_rdata[15];
    // Redirect outranks stall; stall only freezes when no redirect is pending.
    assign advance  = !redirect_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    state_next = FETCH;
                end else if (advance && two_word) begin
                    state_next = IMM;
                end
            end
            IMM: begin
                if (redirect_valid || advance) begin
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_next      = pc_reg;
        hold_ir_next = hold_ir_reg;
        hold_pc_next = hold_pc_reg;
        ir_next      = ir_reg;
        imm_next     = imm_reg;
        pc_out_next  = pc_out_reg;
        valid_next   = valid_reg;
        case (state_reg)
            BOOT: begin
                pc_next    = imem_rdata;
                valid_next = 1'b0;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end else if (advance) begin
                    pc_next = pc_reg + 16'd1;
                    if (two_word) begin
                        hold_ir_next = imem_rdata;
                        hold_pc_next = pc_reg;
                        valid_next   = 1'b0;
                    end else begin
                        ir_next     = imem_rdata;
                        imm_next    = 16'h0000;
                        pc_out_next = pc_reg;
                        valid_next  = 1'b1;
                    end
                end
            end
            IMM: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end else if (advance) begin
                    ir_next     = hold_ir_reg;
                    imm_next    = imem_rdata;
                    pc_out_next = hold_pc_reg;
                    valid_next  = 1'b1;
                    pc_next     = pc_reg + 16'd1;
                end
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg      <= 16'h0000;
            hold_ir_reg <= 16'h0000;
            hold_pc_reg <= 16'h0000;
            ir_reg      <= 16'h0000;
            imm_reg     <= 16'h0000;
            pc_out_reg  <= 16'h0000;
            valid_reg   <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            hold_ir_reg <= hold_ir_next;
            hold_pc_reg <= hold_pc_next;
            ir_reg      <= ir_next;
            imm_reg     <= imm_next;
            pc_out_reg  <= pc_out_next;
            valid_reg   <= valid_next;
        end
    end

    // BOOT always reads the reset vector from word 0.
    assign imem_addr = (state_reg == BOOT) ? 16'h0000 : pc_reg;
    assign ir_out    = ir_reg;
    assign imm_out   = imm_reg;
    assign pc_out    = pc_out_reg;
    assign valid_out = valid_reg;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port stall  input  1  hold request from downstream hazard logic.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-005 SHALL have port redirect_pc  input  16  target word address for redirect.
REQ-006 SHALL have port imem_rdata  input  16  instruction memory word at imem_addr, asynchronous (same-cycle) read.
REQ-007 SHALL have port imem_addr  output  16  instruction memory word address, driven combinationally from internal PC (0 in BOOT).
REQ-008 SHALL have port ir_out  output  16  fetched instruction word, feeds fetch/decode pipeline register input.
REQ-009 SHALL have port imm_out  output  16  immediate word of two-word instruction, 0 for one-word instruction.
REQ-010 SHALL have port pc_out  output  16  address of first word of the instruction on ir_out.
REQ-011 SHALL have port valid_out  output  1  ir_out/imm_out/pc_out hold a valid instruction.

Function
REQ-012 SHALL implement states BOOT, FETCH, IMM, all registered; ir_out, imm_out, pc_out, valid_out registered.
REQ-013 SHALL, in BOOT, drive imem_addr=0, load PC<=imem_rdata (reset vector), keep valid_out<=0, go to FETCH; BOOT lasts exactly one cycle.
REQ-014 SHALL classify word w as two-word when w[15]=1, one-word when w[15]=0.
REQ-015 SHALL, in FETCH with one-word w: ir_out<=w, imm_out<=0, pc_out<=PC, valid_out<=1, PC<=PC+1, stay FETCH (throughput 1 instr/cycle).
REQ-016 SHALL, in FETCH with two-word w: hold_ir<=w, hold_pc<=PC, PC<=PC+1, valid_out<=0, go IMM.
REQ-017 SHALL, in IMM: ir_out<=hold_ir, imm_out<=imem_rdata, pc_out<=hold_pc, valid_out<=1, PC<=PC+1, go FETCH.
REQ-018 SHALL make outputs appear one cycle after the final word is on imem_rdata (latency 1 for one-word, 2 for two-word from first-word address).
REQ-019 SHALL, when stall=1 and redirect_valid=0 in FETCH/IMM, hold PC, state, hold regs and all outputs unchanged (valid_out keeps its value).
REQ-020 SHALL, when redirect_valid=1 in FETCH/IMM, regardless of stall: PC<=redirect_pc, state<=FETCH, valid_out<=0, discard any partial two-word instruction; ir_out/imm_out/pc_out hold.
REQ-021 SHALL ignore stall and redirect_valid in BOOT.
REQ-022 SHALL wrap PC modulo 2^16 (16'hFFFF+1=16'h0000); two-word instruction at 16'hFFFF takes immediate from 16'h0000.
REQ-023 SHALL have priority reset > redirect_valid > stall > normal sequencing.

Reset
REQ-024 SHALL, on reset=1 at posedge clk, set state=BOOT, PC=0, hold_ir=0, hold_pc=0, ir_out=0, imm_out=0, pc_out=0, valid_out=0.
REQ-025 SHALL, on reset asserted mid-operation (including in IMM), abandon the instruction and restart from BOOT, re-reading reset vector.
REQ-026 SHALL hold reset state for as long as reset=1; BOOT executes on first edge with reset=0.

Verification
REQ-027 SHALL cover boot: mem[0]=16'h0010, mem[16]=16'h0001, mem[17]=16'h0002 -> after reset release, cycle 2 ir_out=0001 pc_out=0010 valid=1, cycle 3 ir_out=0002 pc_out=0011.
REQ-028 SHALL cover two-word: mem[16]=16'h8005, mem[17]=16'h1234 -> one cycle valid_out=0, then ir_out=8005, imm_out=1234, pc_out=0010, valid_out=1; next fetch from 0012.
REQ-029 SHALL cover stall: stall=1 for 3 cycles after ir_out=0001 -> outputs and imem_addr constant 3 cycles, sequence resumes with 0002, no instruction lost or duplicated beyond the held value.
REQ-030 SHALL cover redirect: redirect_valid=1, redirect_pc=16'h0040 while in IMM with stall=1 -> next cycle valid_out=0, imem_addr=0040; partial 8005 never emitted.
REQ-031 SHALL cover wrap: PC=16'hFFFF, mem[FFFF]=16'h8001, mem[0000]=16'hABCD -> ir_out=8001, imm_out=ABCD, pc_out=FFFF, next imem_addr=0001.
REQ-032 SHALL cover reset mid-IMM: reset=1 one cycle during IMM -> all outputs 0 next cycle, BOOT re-reads mem[0], fetching restarts at the vector.
